// File: rtl/rf_scoreboard.sv
// Issue-side scoreboard for the 8-entry bypassing register file: counts in-flight
// writers per register and stalls issue on hazards the write bypass cannot cover.
module rf_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic [2:0] read1regsel,
    input  logic       read1used,
    input  logic [2:0] read2regsel,
    input  logic       read2used,
    input  logic [2:0] destregsel,
    input  logic       destvalid,
    input  logic       write,
    input  logic [2:0] writeregsel,
    output logic       stall,
    output logic [7:0] busy,
    output logic       err
);

    logic [1:0] cnt_q [0:7];
    logic [1:0] cnt_d [0:7];
    logic       err_q;
    logic       err_d;

    logic [7:0] ret;
    logic [7:0] inc;
    logic       src1_hazard;
    logic       src2_hazard;
    logic       dest_hazard;
    logic       accept;

    always_comb begin
        ret = 8'h00;
        for (int r = 0; r < 8; r++) begin
            ret[r] = write & (writeregsel == r[2:0]);
        end
    end

    // A lone outstanding writer retiring this cycle is forwarded by the register file.
    always_comb begin
        src1_hazard = read1used & (cnt_q[read1regsel] != 2'd0)
                      & ~(ret[read1regsel] & (cnt_q[read1regsel] == 2'd1));
        src2_hazard = read2used & (cnt_q[read2regsel] != 2'd0)
                      & ~(ret[read2regsel] & (cnt_q[read2regsel] == 2'd1));
        dest_hazard = destvalid & (cnt_q[destregsel] == 2'd3) & ~ret[destregsel];
        stall       = issue & (src1_hazard | src2_hazard | dest_hazard);
        accept      = issue & ~stall & destvalid;
    end

    always_comb begin
        inc   = 8'h00;
        err_d = err_q;
        for (int r = 0; r < 8; r++) begin
            inc[r]   = accept & (destregsel == r[2:0]);
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !ret[r]) begin
                if (cnt_q[r] == 2'd3) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 2'd1;
                end
            end else if (ret[r] && !inc[r]) begin
                if (cnt_q[r] == 2'd0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= 2'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        busy = 8'h00;
        for (int r = 0; r < 8; r++) begin
            busy[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: hand-computed stall/busy/err values per step.
module tb_rf_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue;
    logic [2:0] read1regsel;
    logic       read1used;
    logic [2:0] read2regsel;
    logic       read2used;
    logic [2:0] destregsel;
    logic       destvalid;
    logic       write;
    logic [2:0] writeregsel;
    logic       stall;
    logic [7:0] busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .read1regsel (read1regsel),
        .read1used   (read1used),
        .read2regsel (read2regsel),
        .read2used   (read2used),
        .destregsel  (destregsel),
        .destvalid   (destvalid),
        .write       (write),
        .writeregsel (writeregsel),
        .stall       (stall),
        .busy        (busy),
        .err         (err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iss, input logic [2:0] r1, input logic r1u,
                         input logic [2:0] r2, input logic r2u,
                         input logic [2:0] d, input logic dv,
                         input logic w, input logic [2:0] ws);
        issue       = iss;
        read1regsel = r1;
        read1used   = r1u;
        read2regsel = r2;
        read2used   = r2u;
        destregsel  = d;
        destvalid   = dv;
        write       = w;
        writeregsel = ws;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 4, 1, 1, 6);
        tick();
        tick();
        rst = 1'b0;
        idle();
        check("reset_busy", busy, 8'h00);
        check("reset_err", {7'b0, err}, 8'h00);
        check("reset_stall", {7'b0, stall}, 8'h00);

        // issue dest r3, no sources
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        check("issue_r3_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("issue_r3_busy", busy, 8'h08);

        // RAW with bypass on r5
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        check("issue_r5_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("issue_r5_busy", busy, 8'h28);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        check("raw_stall_a", {7'b0, stall}, 8'h01);
        tick();
        check("raw_busy_hold", busy, 8'h28);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        check("raw_stall_b", {7'b0, stall}, 8'h01);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 5);
        check("raw_bypass_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("raw_retire_busy", busy, 8'h08);

        // unused source does not stall
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        idle();
        check("unused_setup_busy", busy, 8'h28);
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0);
        check("unused_src2_stall", {7'b0, stall}, 8'h00);
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
        check("used_src2_stall", {7'b0, stall}, 8'h01);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5);
        tick();
        idle();
        check("unused_clear_busy", busy, 8'h08);

        // saturation on r2
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
            check("sat_issue_stall", {7'b0, stall}, 8'h00);
            tick();
        end
        idle();
        check("sat_busy", busy, 8'h0c);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
        check("sat_fourth_stall", {7'b0, stall}, 8'h01);
        tick();
        idle();
        check("sat_fourth_busy", busy, 8'h0c);
        check("sat_fourth_err", {7'b0, err}, 8'h00);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 2);
        check("sat_retire_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("sat_retire_busy", busy, 8'h0c);
        check("sat_retire_err", {7'b0, err}, 8'h00);
        // drain r2: cnt 3 -> 2 -> 1 -> 0
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        tick();
        tick();
        check("sat_drain_mid_busy", busy, 8'h0c);
        tick();
        idle();
        check("sat_drain_busy", busy, 8'h08);
        check("sat_drain_err", {7'b0, err}, 8'h00);

        // two writers of r1 in flight
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        idle();
        check("dbl_busy", busy, 8'h0a);
        drive(1, 1, 1, 0, 0, 0, 0, 1, 1);
        check("dbl_first_retire_stall", {7'b0, stall}, 8'h01);
        tick();
        idle();
        check("dbl_first_retire_busy", busy, 8'h0a);
        drive(1, 0, 0, 1, 1, 0, 0, 1, 1);
        check("dbl_second_retire_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("dbl_second_retire_busy", busy, 8'h08);

        // r3 still has one writer: both sources and dest on r3 must stall
        drive(1, 3, 1, 3, 1, 3, 1, 0, 0);
        check("same_reg_stall", {7'b0, stall}, 8'h01);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        idle();
        check("r3_clear_busy", busy, 8'h00);
        check("r3_clear_err", {7'b0, err}, 8'h00);

        // underflow on r7, sticky error
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        idle();
        check("underflow_err", {7'b0, err}, 8'h01);
        check("underflow_busy", busy, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("r0_issue_stall", {7'b0, stall}, 8'h00);
        tick();
        idle();
        check("r0_busy", busy, 8'h01);
        check("err_sticky", {7'b0, err}, 8'h01);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        rst = 1'b0;
        idle();
        check("rst_clear_err", {7'b0, err}, 8'h00);
        check("rst_clear_busy", busy, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file scoreboard: the issue-side counterpart to the bypassing register file. It sits beside decode, tracks how many in-flight instructions will still write each of the 8 architectural registers, and stalls issue whenever a source register has an outstanding writer that the same-cycle write bypass cannot cover. Writeback drives its retire port with the same write/writeregsel pair it drives into the register file.

## Interface
Parameters:
- none. 8 registers, 3-bit selectors, 2-bit pending counters are fixed.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- issue  in  1  decode presents an instruction this cycle
- read1regsel  in  3  source register 1
- read1used  in  1  source 1 is actually read
- read2regsel  in  3  source register 2
- read2used  in  1  source 2 is actually read
- destregsel  in  3  destination register of issuing instruction
- destvalid  in  1  issuing instruction writes destregsel
- write  in  1  writeback retires a register write (same signal as the register file's write)
- writeregsel  in  3  register being retired (same as the register file's writeregsel)
- stall  out  1  issue must not proceed this cycle (combinational)
- busy  out  8  bit r = pending count of register r is nonzero (registered)
- err  out  1  sticky protocol error (registered)

## Operation
- State: cnt[r], 2 bits, r = 0..7, counting in-flight writers; err_q sticky flag.
- Retire hit for r: ret[r] = write & (writeregsel == r).
- Source hazard on sel: used & cnt[sel] != 0 & !(ret[sel] & cnt[sel] == 1). A single outstanding writer that retires this cycle is covered by the register file's write-to-read bypass, so it is not a hazard.
- Dest hazard: destvalid & cnt[destregsel] == 3 & !ret[destregsel].
- stall = issue & (src1 hazard | src2 hazard | dest hazard).
- Accept = issue & !stall & destvalid; inc[r] = accept & (destregsel == r).
- Counter update per r: inc & ret gives cnt unchanged; inc only gives cnt+1; ret only with cnt != 0 gives cnt-1; ret only with cnt == 0 is an underflow: cnt stays 0 and err_q is set.
- Overflow cannot occur by construction. Any increment that would wrap 3 to 0 is also a design error: set err_q and hold cnt at 3.
- err_q, once set, stays set until rst. busy[r] = (cnt[r] != 0), taken from the registered counters.
- No register is hardwired; r = 0 is tracked like any other.
- A stalled instruction causes no state change. Retires proceed regardless of stall.

## Timing
- Reset: on a rising edge with rst = 1, all cnt become 0, busy = 8'h00, err = 0. Inputs are ignored that cycle. With cnt = 0, stall = 0.
- Reset mid-operation discards all pending counts; retires after reset with cnt = 0 set err (writeback must be flushed with reset).
- stall is a same-cycle combinational function of the inputs and current cnt. There is no registered path, and stall must not depend on itself.
- Counter and busy effects of an accepted issue or a retire are visible on busy the cycle after the edge.
- A dependent instruction issued the cycle after its producer is accepted sees cnt = 1. It stalls until the producer's retire cycle, and issues in that cycle via the bypass.
- Simultaneous events: issue and retire of the same register in one cycle leave cnt unchanged. Both sources equal to the destination are handled with the pre-update cnt.

## Test plan
- Reset, then idle: busy = 8'h00, err = 0, stall = 0. Issue dest r3 with no sources: next cycle busy = 8'h08.
- RAW with bypass: issue dest r5, then hold issue with read1regsel = 5, read1used = 1. stall = 1 until the cycle write = 1, writeregsel = 5, where stall = 0. Next cycle busy[5] = 0.
- Unused source: read2regsel = 5 with read2used = 0 while busy[5] = 1 gives stall = 0.
- Saturation: three accepted issues to r2 give cnt = 3. A fourth gives stall = 1. The fourth concurrent with a retire of r2 gives stall = 0 and cnt stays 3.
- Double writer: two writers of r1 in flight. A reader of r1 during the first retire gives stall = 1 (cnt = 2). A reader during the second retire gives stall = 0.
- Underflow: write = 1, writeregsel = 7 with busy[7] = 0 gives err = 1 next cycle, held through later traffic, cleared only by rst = 1.
